// File: rtl/spi_word_sequencer_pkg.sv
// Shared types and sizing helpers for the SPI word sequencer.
package spi_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        WAIT = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    function automatic int cnt_width(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_word_sequencer_if.sv
// Word handshake, byte-controller link and FSM debug view of spi_word_sequencer.
// valid/ready: a word moves on the clk_in edge where word_valid_in and word_ready_out are both high, word_in held until then; word_valid_out, byte_trigger_out and byte_valid_in are one-cycle strobes with no back-pressure.
interface spi_word_sequencer_if #(
    parameter int BYTE_WIDTH = 8,
    parameter int WORD_BYTES = 4
);
    import spi_seq_pkg::*;

    localparam int WORD_WIDTH = WORD_BYTES * BYTE_WIDTH;

    logic [WORD_WIDTH-1:0] word_in;
    logic                  word_valid_in;
    logic                  word_ready_out;
    logic [WORD_WIDTH-1:0] word_out;
    logic                  word_valid_out;
    logic [BYTE_WIDTH-1:0] byte_out;
    logic                  byte_trigger_out;
    logic [BYTE_WIDTH-1:0] byte_in;
    logic                  byte_valid_in;
    logic                  busy_out;
    logic                  error_out;
    state_t                state_dbg;

    modport slave (
        input  word_in, word_valid_in, byte_in, byte_valid_in,
        output word_ready_out, word_out, word_valid_out, byte_out,
               byte_trigger_out, busy_out, error_out, state_dbg
    );

    modport master (
        output word_in, word_valid_in, byte_in, byte_valid_in,
        input  word_ready_out, word_out, word_valid_out, byte_out,
               byte_trigger_out, busy_out, error_out, state_dbg
    );

endinterface

// File: rtl/spi_word_sequencer.sv
// Splits a word into MSB-first bytes for a byte SPI controller and reassembles the reply word.
// Defining SPI_SEQ_TIMEOUT_EN adds a per-byte watchdog that aborts a stalled transfer.
module spi_word_sequencer
    import spi_seq_pkg::*;
#(
    parameter int BYTE_WIDTH     = 8,
    parameter int WORD_BYTES     = 4,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input logic                 clk_in,
    input logic                 rst_in,
    spi_word_sequencer_if.slave bus
);
    localparam int WORD_WIDTH = WORD_BYTES * BYTE_WIDTH;
    localparam int IDX_W      = cnt_width(WORD_BYTES);
    localparam int GAP_W      = cnt_width(GAP_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    if (WORD_BYTES < 1 || BYTE_WIDTH < 1 || GAP_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("spi_word_sequencer: illegal parameter set");
    end

    state_t                state;
    state_t                state_nxt;
    logic [WORD_WIDTH-1:0] tx_reg;
    logic [WORD_WIDTH-1:0] rx_reg;
    logic [WORD_WIDTH-1:0] rx_shift;
    logic [WORD_WIDTH-1:0] word_q;
    logic [IDX_W-1:0]      byte_idx;
    logic [GAP_W-1:0]      gap_cnt;

    // Received bytes enter at the bottom so the first one ends up in the top byte.
    assign rx_shift = WORD_WIDTH'({rx_reg, bus.byte_in});

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int WD_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout;

    assign timeout       = (state == WAIT) && !bus.byte_valid_in && (wd_cnt == WD_LAST);
    assign bus.error_out = timeout;
`else
    assign bus.error_out = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.word_valid_in) state_nxt = LOAD;
            LOAD: state_nxt = WAIT;
            WAIT: begin
                if (bus.byte_valid_in) begin
                    if (byte_idx == IDX_LAST)  state_nxt = DONE;
                    else if (GAP_CYCLES > 0)   state_nxt = GAP;
                    else                       state_nxt = LOAD;
                end
`ifdef SPI_SEQ_TIMEOUT_EN
                else if (timeout) begin
                    state_nxt = IDLE;
                end
`endif
            end
            GAP:     if (gap_cnt == GAP_LAST) state_nxt = LOAD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tx_reg   <= '0;
            rx_reg   <= '0;
            word_q   <= '0;
            byte_idx <= '0;
            gap_cnt  <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
            wd_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.word_valid_in) begin
                        tx_reg   <= bus.word_in;
                        rx_reg   <= '0;
                        byte_idx <= '0;
                    end
                end
                LOAD: begin
`ifdef SPI_SEQ_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (bus.byte_valid_in) begin
                        rx_reg  <= rx_shift;
                        tx_reg  <= tx_reg << BYTE_WIDTH;
                        gap_cnt <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
                        wd_cnt  <= '0;
`endif
                        // word_out is loaded here so it is already valid in the DONE cycle.
                        if (byte_idx == IDX_LAST) word_q   <= rx_shift;
                        else                      byte_idx <= byte_idx + IDX_W'(1);
                    end
`ifdef SPI_SEQ_TIMEOUT_EN
                    else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end
                GAP:     gap_cnt <= gap_cnt + GAP_W'(1);
                default: ;
            endcase
        end
    end

    assign bus.word_ready_out   = (state == IDLE);
    assign bus.busy_out         = (state != IDLE);
    assign bus.byte_trigger_out = (state == LOAD);
    assign bus.byte_out         = tx_reg[WORD_WIDTH-1 -: BYTE_WIDTH];
    assign bus.word_valid_out   = (state == DONE);
    assign bus.word_out         = word_q;
    assign bus.state_dbg        = state;

endmodule

// File: tb/tb_spi_word_sequencer.sv
// Directed bench for spi_word_sequencer: one instance with a 4-cycle gap, one with no gap,
// each driven by a behavioural byte-controller model.
module tb_spi_word_sequencer;
    import spi_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    spi_word_sequencer_if #(.BYTE_WIDTH(8), .WORD_BYTES(4)) ifa ();
    spi_word_sequencer_if #(.BYTE_WIDTH(8), .WORD_BYTES(4)) ifb ();

    spi_word_sequencer #(.BYTE_WIDTH(8), .WORD_BYTES(4), .GAP_CYCLES(4), .TIMEOUT_CYCLES(50))
        dut_a (.clk_in(clk), .rst_in(rst), .bus(ifa.slave));
    spi_word_sequencer #(.BYTE_WIDTH(8), .WORD_BYTES(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(50))
        dut_b (.clk_in(clk), .rst_in(rst), .bus(ifb.slave));

    logic [7:0]  exp_q[$];
    logic [7:0]  trig_a[$];
    int          trig_cyc_a[$];
    int          acc_cyc_a[$];
    int          wv_cyc_a[$];
    logic [31:0] wout_a[$];
    int          viol_a = 0;
    int          err_a = 0;
    int          trig_cyc_b[$];
    int          acc_cyc_b[$];
    int          wv_cyc_b[$];
    int          resp_cyc_b[$];
    logic [31:0] wout_b[$];

    logic        a_fixed = 1'b0;
    logic        a_silent = 1'b0;
    logic        a_spur = 1'b0;
    int          a_fix_idx = 0;
    int          a_resp_n = 0;
    logic [7:0]  fix_tab[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Controller model for dut_a: 10 cycles per byte, loopback / fixed table / silent.
    initial begin
        logic       trig;
        logic [7:0] cap;
        logic       rst_s;
        state_t     st;
        int         cnt;
        logic [7:0] hold;
        cnt = 0;
        hold = '0;
        ifa.byte_valid_in = 1'b0;
        ifa.byte_in = '0;
        forever begin
            @(negedge clk);
            trig = ifa.byte_trigger_out;
            cap = ifa.byte_out;
            st = ifa.state_dbg;
            rst_s = rst;
            @(posedge clk);
            #1;
            ifa.byte_valid_in = 1'b0;
            if (rst_s) begin
                cnt = 0;
            end else if (trig) begin
                if (!a_silent) begin
                    cnt = 9;
                    hold = a_fixed ? fix_tab[a_fix_idx % 4] : cap;
                    if (a_fixed) a_fix_idx++;
                end
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    ifa.byte_valid_in = 1'b1;
                    ifa.byte_in = hold;
                    a_resp_n++;
                end
            end else if (a_spur && st == GAP) begin
                ifa.byte_valid_in = 1'b1;
                ifa.byte_in = 8'h5A;
                a_spur = 1'b0;
            end
        end
    end

    // Controller model for dut_b: loopback, 3 cycles per byte.
    initial begin
        logic       trig;
        logic [7:0] cap;
        logic       rst_s;
        int         cnt;
        logic [7:0] hold;
        cnt = 0;
        hold = '0;
        ifb.byte_valid_in = 1'b0;
        ifb.byte_in = '0;
        forever begin
            @(negedge clk);
            trig = ifb.byte_trigger_out;
            cap = ifb.byte_out;
            rst_s = rst;
            @(posedge clk);
            #1;
            ifb.byte_valid_in = 1'b0;
            if (rst_s) begin
                cnt = 0;
            end else if (trig) begin
                cnt = 2;
                hold = cap;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    ifb.byte_valid_in = 1'b1;
                    ifb.byte_in = hold;
                    resp_cyc_b.push_back(cyc);
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (ifa.byte_trigger_out) begin
            trig_a.push_back(ifa.byte_out);
            trig_cyc_a.push_back(cyc);
        end
        if (ifa.word_valid_in && ifa.word_ready_out) acc_cyc_a.push_back(cyc);
        if (ifa.word_valid_out) begin
            wv_cyc_a.push_back(cyc);
            wout_a.push_back(ifa.word_out);
        end
        if (ifa.word_ready_out && (ifa.busy_out || ifa.word_valid_out)) viol_a++;
        if (ifa.error_out) err_a++;
        if (ifb.byte_trigger_out) trig_cyc_b.push_back(cyc);
        if (ifb.word_valid_in && ifb.word_ready_out) acc_cyc_b.push_back(cyc);
        if (ifb.word_valid_out) begin
            wv_cyc_b.push_back(cyc);
            wout_b.push_back(ifb.word_out);
        end
    end

    task automatic clear_a();
        trig_a.delete();
        trig_cyc_a.delete();
        acc_cyc_a.delete();
        wv_cyc_a.delete();
        wout_a.delete();
    endtask

    task automatic send_a(input logic [31:0] w);
        int ok;
        ok = 0;
        @(posedge clk);
        #1;
        ifa.word_in = w;
        ifa.word_valid_in = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ifa.word_ready_out) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        ifa.word_valid_in = 1'b0;
        chk("send_a_accept", ok, 1);
    endtask

    task automatic send_b(input logic [31:0] w);
        int ok;
        ok = 0;
        @(posedge clk);
        #1;
        ifb.word_in = w;
        ifb.word_valid_in = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ifb.word_ready_out) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        ifb.word_valid_in = 1'b0;
        chk("send_b_accept", ok, 1);
    endtask

    task automatic wait_words_a(input string tag, input int n, input int limit);
        for (int i = 0; i < limit && wout_a.size() < n; i++) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_words"}, wout_a.size(), n);
    endtask

    task automatic check_trigs_a(input string tag);
        logic [7:0] e;
        logic [7:0] g;
        chk({tag, "_trig_count"}, trig_a.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (trig_a.size() > 0) ? trig_a.pop_front() : 8'hxx;
            chk({tag, "_trig_byte"}, g, e);
        end
    endtask

    initial begin
        int ok;
        int base;
        ifa.word_in = '0;
        ifa.word_valid_in = 1'b0;
        ifb.word_in = '0;
        ifb.word_valid_in = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_word_out", ifa.word_out, 32'h0);
        chk("rst_word_valid", ifa.word_valid_out, 1'b0);
        chk("rst_byte_out", ifa.byte_out, 8'h00);
        chk("rst_trigger", ifa.byte_trigger_out, 1'b0);
        chk("rst_busy", ifa.busy_out, 1'b0);
        chk("rst_error", ifa.error_out, 1'b0);
        chk("rst_ready", ifa.word_ready_out, 1'b1);
        chk("rst_state", ifa.state_dbg, IDLE);
        @(posedge clk);
        #1 rst = 1'b0;

        // Loopback of 0xDEADBEEF with GAP_CYCLES=4 and 10-cycle bytes.
        clear_a();
        exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_a(32'hDEADBEEF);
        wait_words_a("lb", 1, 300);
        repeat (5) @(posedge clk);
        #1;
        chk("lb_word", wout_a[0], 32'hDEADBEEF);
        chk("lb_pulses", wv_cyc_a.size(), 1);
        chk("lb_first_trig", trig_cyc_a[0] - acc_cyc_a[0], 1);
        chk("lb_trig_spacing", trig_cyc_a[1] - trig_cyc_a[0], 15);
        chk("lb_done_latency", wv_cyc_a[0] - trig_cyc_a[3], 11);
        check_trigs_a("lb");

        // Fixed controller reply 11 22 33 44.
        clear_a();
        a_fixed = 1'b1;
        a_fix_idx = 0;
        exp_q = '{8'hA5, 8'hA5, 8'hA5, 8'hA5};
        send_a(32'hA5A5A5A5);
        wait_words_a("fix", 1, 300);
        chk("fix_word", wout_a[0], 32'h11223344);
        check_trigs_a("fix");
        a_fixed = 1'b0;

        // word_valid_in held high across two words.
        clear_a();
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        @(posedge clk);
        #1;
        ifa.word_in = 32'h01020304;
        ifa.word_valid_in = 1'b1;
        ok = 0;
        for (int i = 0; i < 600 && ok < 2; i++) begin
            @(negedge clk);
            if (ifa.word_ready_out) begin
                ok++;
                @(posedge clk);
                #1;
                if (ok == 1) ifa.word_in = 32'h05060708;
                else         ifa.word_valid_in = 1'b0;
            end
        end
        wait_words_a("hs", 2, 600);
        repeat (20) @(posedge clk);
        #1;
        chk("hs_acceptances", acc_cyc_a.size(), 2);
        chk("hs_word0", wout_a[0], 32'h01020304);
        chk("hs_word1", wout_a[1], 32'h05060708);
        chk("hs_accept_after_done", acc_cyc_a[1] - wv_cyc_a[0], 1);
        check_trigs_a("hs");
        chk("hs_ready_overlap", viol_a, 0);

        // Spurious byte_valid_in while in GAP.
        clear_a();
        a_spur = 1'b1;
        exp_q = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        send_a(32'h0A0B0C0D);
        wait_words_a("spur", 1, 300);
        chk("spur_injected", a_spur, 1'b0);
        chk("spur_word", wout_a[0], 32'h0A0B0C0D);
        check_trigs_a("spur");

        // Reset after the second byte of 0xCAFEF00D.
        clear_a();
        a_resp_n = 0;
        send_a(32'hCAFEF00D);
        for (int i = 0; i < 300 && a_resp_n < 2; i++) @(negedge clk);
        chk("rst_mid_reached", a_resp_n, 2);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", ifa.busy_out, 1'b0);
        chk("rst_mid_ready", ifa.word_ready_out, 1'b1);
        repeat (30) @(negedge clk);
        chk("rst_mid_no_trig", trig_a.size(), 2);
        chk("rst_mid_no_word", wout_a.size(), 0);
        chk("rst_mid_word_out", ifa.word_out, 32'h0);

        clear_a();
        exp_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        send_a(32'h12345678);
        wait_words_a("post_rst", 1, 300);
        chk("post_rst_word", wout_a[0], 32'h12345678);
        check_trigs_a("post_rst");

        // Zero-gap timing on dut_b.
        send_b(32'h0F1E2D3C);
        for (int i = 0; i < 200 && wout_b.size() < 1; i++) begin
            @(posedge clk);
            #1;
        end
        chk("nogap_words", wout_b.size(), 1);
        chk("nogap_word", wout_b[0], 32'h0F1E2D3C);
        chk("nogap_first_trig", trig_cyc_b[0] - acc_cyc_b[0], 1);
        for (int i = 0; i < 3; i++) chk("nogap_next_trig", trig_cyc_b[i + 1] - resp_cyc_b[i], 1);
        chk("nogap_done_latency", wv_cyc_b[0] - resp_cyc_b[3], 1);

`ifdef SPI_SEQ_TIMEOUT_EN
        clear_a();
        a_silent = 1'b1;
        send_a(32'h99887766);
        for (int i = 0; i < 50 && trig_cyc_a.size() < 1; i++) begin
            @(posedge clk);
            #1;
        end
        chk("to_trig_seen", trig_cyc_a.size(), 1);
        base = trig_cyc_a[0];
        for (int i = 0; i < 200 && cyc < base + 50; i++) @(negedge clk);
        chk("to_error_pulse", ifa.error_out, 1'b1);
        @(negedge clk);
        chk("to_error_single", ifa.error_out, 1'b0);
        chk("to_state_idle", ifa.state_dbg, IDLE);
        chk("to_word_kept", ifa.word_out, 32'h12345678);
        chk("to_no_word", wout_a.size(), 0);
        chk("to_error_count", err_a, 1);
        a_silent = 1'b0;
`else
        base = 0;
        chk("error_tied_low", err_a + base, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1, "bench did not complete");
    end

endmodule

// File: doc/spi_word_sequencer.md
Name: spi_word_sequencer

Overview:
- Sits directly upstream of the byte-level SPI controller (8-bit, MSB-first, one byte per trigger).
- Accepts a wide word over a valid/ready handshake and splits it into bytes, most-significant byte first.
- Issues one controller trigger per byte, waits for that byte's completion pulse, and shifts the received bytes into a wide response word.
- Presents the response with a single-cycle valid pulse; used for exchanging multi-byte operands between boards.

Parameters:
BYTE_WIDTH, 8, width of one controller transfer; must equal the controller's DATA_WIDTH
WORD_BYTES, 4, bytes per word; >=1
GAP_CYCLES, 4, idle clk_in cycles between a byte's completion and the next trigger; 0 allowed
TIMEOUT_CYCLES, 100000, per-byte watchdog limit; used only with SPI_SEQ_TIMEOUT_EN

Ports:
clk_in  input  1  system clock (100 MHz)
rst_in  input  1  synchronous, active-high reset
word_in  input  WORD_BYTES*BYTE_WIDTH  word to transmit
word_valid_in  input  1  word_in is valid
word_ready_out  output  1  high only in IDLE; a word is accepted when valid and ready are both high
word_out  output  WORD_BYTES*BYTE_WIDTH  received word
word_valid_out  output  1  one-cycle pulse when word_out is updated
byte_out  output  BYTE_WIDTH  byte to the controller's data_in
byte_trigger_out  output  1  one-cycle pulse to the controller's trigger_in
byte_in  input  BYTE_WIDTH  from the controller's data_out
byte_valid_in  input  1  from the controller's data_valid_out; marks byte completion
busy_out  output  1  high in any state other than IDLE
error_out  output  1  one-cycle pulse on a timeout abort; constant 0 without the macro

Behaviour:
- Reset values: word_out=0, word_valid_out=0, byte_out=0, byte_trigger_out=0, busy_out=0, error_out=0, word_ready_out=1; state=IDLE; internal tx/rx registers and counters cleared.
- States and transitions:
  - IDLE: on word_valid_in && word_ready_out, latch word_in into tx_reg, clear rx_reg, set byte_idx=0, go to LOAD.
  - LOAD (one cycle): byte_out <= tx_reg[top BYTE_WIDTH bits]; byte_trigger_out pulses high for exactly this cycle; go to WAIT.
  - WAIT: hold byte_out stable. On byte_valid_in:
    - rx_reg <= {rx_reg[lower bits], byte_in}; tx_reg shifts left by BYTE_WIDTH.
    - If byte_idx==WORD_BYTES-1, go to DONE.
    - Otherwise increment byte_idx, then go to GAP if GAP_CYCLES>0, else to LOAD.
  - GAP: count GAP_CYCLES cycles, then go to LOAD.
  - DONE (one cycle): word_out <= rx_reg (including the final byte); word_valid_out=1; go to IDLE.
- Latency:
  - Acceptance at cycle t gives the first trigger at t+1.
  - A byte_valid_in at cycle c gives the next trigger at c+GAP_CYCLES+1.
  - The final byte_valid_in at cycle c gives word_valid_out at c+1.
- Byte order: the first byte sent is word_in[top BYTE_WIDTH bits]; the first byte received lands in word_out[top BYTE_WIDTH bits].
- byte_valid_in outside WAIT is ignored. word_valid_in while busy is ignored (ready is low); the word is not queued.
- A new word can be accepted in the cycle after DONE. word_valid_out and word_ready_out are never high in the same cycle.
- WORD_BYTES=1: the sequence is LOAD→WAIT→DONE and the gap is never entered.
- byte_idx width is max(1,$clog2(WORD_BYTES)). The gap counter is sized for GAP_CYCLES and the watchdog for TIMEOUT_CYCLES.
- Reset mid-operation: return to IDLE immediately with no further trigger. The controller shares rst_in, so both ends abort together; the partial rx word is discarded.

Optional Feature:
- Macro: SPI_SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in WAIT and clears on each byte_valid_in.
  - If it reaches TIMEOUT_CYCLES, error_out pulses for 1 cycle and the block returns to IDLE.
  - word_valid_out is not asserted and word_out is unchanged.
- Undefined: no watchdog; WAIT waits indefinitely; error_out is tied 0.

Decomposition:
- Package spi_seq_pkg holds:
  - the state enum typedef: IDLE, LOAD, WAIT, GAP, DONE;
  - a localparam function computing counter width max(1,$clog2(n)).
- No sub-module: the counters and shift registers are small and inline in one always_ff.

Test Plan:
- Loopback, WORD_BYTES=4, GAP_CYCLES=4. The bench models the controller with 10 cycles per byte and returns byte_out.
  - Stimulus: word 0xDEADBEEF.
  - Triggers carry DE, AD, BE, EF in that order; word_out=0xDEADBEEF with one word_valid_out pulse.
- Fixed response: the model returns 0x11,0x22,0x33,0x44 for word 0xA5A5A5A5 → word_out=0x11223344.
- Timing, GAP_CYCLES=0:
  - Each next trigger occurs exactly 1 cycle after byte_valid_in.
  - A word accepted at t gives its first trigger at t+1.
- Handshake:
  - word_valid_in held high across two words (0x01020304 then 0x05060708): exactly two acceptances, ready low throughout each transfer, no dropped or duplicated bytes.
  - A spurious byte_valid_in during GAP does not advance byte_idx.
- Reset after the second byte of 0xCAFEF00D: busy_out=0 and word_ready_out=1 next cycle, no further trigger, no word_valid_out. A new word 0x12345678 then completes normally.
- With SPI_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=50: the model never answers the first byte.
  - error_out pulses at cycle 50 of WAIT; state returns to IDLE; word_out keeps its previous value.
